input_shift_register: RTL and testbench
=======================================

Name: input_shift_register

Overview:
- PIO state-machine Input Shift Register (ISR): the receive-direction counterpart of the OSR.
- An IN instruction shifts 1–32 bits from a source into the ISR. PUSH, or autopush on reaching a threshold, transfers the ISR word into the RX FIFO.
- MOV writes the ISR directly; the ISR contents are exposed for MOV-from-ISR.
- A combinational stall tells the state-machine sequencer to hold the current instruction.

Parameters:
- none; datapath fixed at 32 bits, counter 6 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- mov_in  input  32  MOV destination data
- mov_en  input  1  MOV to ISR this cycle
- in_data  input  32  IN source value; only low true_count bits used
- shift_en  input  1  IN instruction this cycle
- shift_count  input  5  IN bit count; 0 means 32
- shiftdir  input  1  0 = shift left, 1 = shift right
- autopush  input  1  enable autopush
- push_thresh  input  5  push threshold; 0 means 32
- push_en  input  1  PUSH instruction this cycle
- push_iffull  input  1  PUSH is a no-op unless counter >= threshold
- push_block  input  1  PUSH stalls while FIFO is full
- fifo_full  input  1  RX FIFO full
- fifo_data  output  32  word presented to RX FIFO
- fifo_push  output  1  one-cycle write strobe to RX FIFO
- isr  output  32  current ISR contents
- input_shift_counter  output  6  bits shifted in since last clear, 0..32
- stall  output  1  combinational; instruction must be held and retried

Behaviour:
- Reset: isr = 0, input_shift_counter = 0, fifo_data = 0, fifo_push = 0. Async assert; release is synchronous to clk.
- Derived values:
  - true_count = shift_count, or 32 when shift_count = 0.
  - thresh = push_thresh, or 32 when push_thresh = 0.
  - next_cnt = min(counter + true_count, 32), computed in 7 bits before saturating.
  - mask = low true_count bits of in_data.
- Shifted value (sv):
  - shiftdir = 0: sv = (isr << true_count) | mask.
  - shiftdir = 1: sv = (isr >> true_count) | (mask << (32 − true_count)).
  - true_count = 32 in either direction: sv = in_data.
- Priority: mov_en > push_en > shift_en. The sequencer keeps these mutually exclusive; the priority exists only for robustness.
- MOV: isr <= mov_in; counter <= 0; fifo_push <= 0.
- PUSH:
  - push_iffull = 1 and counter < thresh: no-op, no stall.
  - FIFO not full: fifo_data <= isr; fifo_push <= 1; isr <= 0; counter <= 0.
  - FIFO full and push_block = 1: stall = 1, no state change.
  - FIFO full and push_block = 0: no write (fifo_push = 0), but isr <= 0 and counter <= 0.
- IN, no autopush, or next_cnt < thresh: isr <= sv; counter <= next_cnt; fifo_push <= 0.
- IN with autopush = 1 and next_cnt >= thresh:
  - FIFO not full: fifo_data <= sv; fifo_push <= 1; isr <= 0; counter <= 0. The shifted word is pushed in the same cycle (one-cycle latency to the fifo_push strobe).
  - FIFO full: stall = 1; isr and counter unchanged. The IN is retried each cycle until the FIFO has space.
- Idle cycle (no enable): fifo_push <= 0; isr and counter hold.
- fifo_push is high for exactly one cycle per push. fifo_data holds its last value otherwise.
- stall is combinational from the current inputs and state. It is never asserted when no enable is active.
- Counter saturates at 32. Further IN without a push leaves it at 32 and still shifts data.
- Reset mid-stall: state clears immediately and stall drops.

Test Plan:
- Reset, then 4×IN left of 8 bits with in_data = 0x11, 0x22, 0x33, 0x44, autopush off -> isr = 0x11223344, counter = 32, no fifo_push.
- IN right, count 0 (32), in_data = 0xDEADBEEF -> isr = 0xDEADBEEF. Then IN right of 4 bits, data 0xA -> isr = 0xADEADBEE, counter stays 32.
- autopush = 1, thresh = 16, two IN left of 8 bits (0xAB, 0xCD) with fifo_full = 0 -> second cycle gives fifo_push = 1, fifo_data = 0x0000ABCD, then isr = 0, counter = 0.
- Same as previous with fifo_full = 1 during the second IN -> stall = 1, isr = 0xAB, counter = 8 held. Deassert fifo_full -> push of 0x0000ABCD the next cycle, stall = 0.
- PUSH cases:
  - push_iffull = 1 with counter = 8, thresh = 32 -> no push, no stall.
  - push_block = 0 with fifo_full = 1 -> isr = 0, counter = 0, fifo_push = 0.
  - push_block = 1 with fifo_full = 1 -> stall = 1, isr unchanged.
- MOV 0x12345678 after counter = 20 -> isr = 0x12345678, counter = 0. Assert rst mid-sequence -> isr, counter, fifo_data and fifo_push all 0 immediately.

Source files
------------

// File: rtl/input_shift_register_if.sv
// Bundle between the state-machine sequencer and its Input Shift Register.
// The sequencer drives the instruction controls and the ISR returns data, the FIFO write and stall.
interface input_shift_register_if;
  logic [31:0] mov_in;
  logic        mov_en;
  logic [31:0] in_data;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic        push_en;
  logic        push_iffull;
  logic        push_block;
  logic        fifo_full;
  logic [31:0] fifo_data;
  logic        fifo_push;
  logic [31:0] isr;
  logic [5:0]  input_shift_counter;
  logic        stall;

  modport master (
    output mov_in, mov_en, in_data, shift_en, shift_count, shiftdir,
           autopush, push_thresh, push_en, push_iffull, push_block, fifo_full,
    input  fifo_data, fifo_push, isr, input_shift_counter, stall
  );

  modport slave (
    input  mov_in, mov_en, in_data, shift_en, shift_count, shiftdir,
           autopush, push_thresh, push_en, push_iffull, push_block, fifo_full,
    output fifo_data, fifo_push, isr, input_shift_counter, stall
  );
endinterface

// File: rtl/input_shift_register.sv
// PIO Input Shift Register: IN shifts bits in, PUSH/autopush hands the word to the RX FIFO,
// MOV loads it directly. stall asks the sequencer to retry the current instruction.
module input_shift_register (
  input logic                   clk,
  input logic                   rst,
  input_shift_register_if.slave bus
);

  logic [31:0] isr_q, isr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] fifo_data_q, fifo_data_d;
  logic        fifo_push_q, fifo_push_d;
  logic        stall_d;

  logic [5:0]  true_count;
  logic [5:0]  thresh;
  logic [6:0]  cnt_sum;
  logic [5:0]  next_cnt;
  logic [31:0] mask;
  logic [31:0] shifted;

  // Encoded zero means a full 32 for both the shift width and the threshold.
  assign true_count = (bus.shift_count == 5'd0) ? 6'd32 : {1'b0, bus.shift_count};
  assign thresh     = (bus.push_thresh == 5'd0) ? 6'd32 : {1'b0, bus.push_thresh};
  assign cnt_sum    = {1'b0, cnt_q} + {1'b0, true_count};
  assign next_cnt   = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

  // Full-width shifts are special-cased so no shift by 32 is ever evaluated.
  always_comb begin
    mask    = bus.in_data & ~(32'hFFFF_FFFF << true_count[4:0]);
    shifted = bus.in_data;
    if (true_count != 6'd32) begin
      if (bus.shiftdir)
        shifted = (isr_q >> true_count[4:0]) | (mask << (6'd32 - true_count));
      else
        shifted = (isr_q << true_count[4:0]) | mask;
    end
  end

  always_comb begin
    isr_d       = isr_q;
    cnt_d       = cnt_q;
    fifo_data_d = fifo_data_q;
    fifo_push_d = 1'b0;
    stall_d     = 1'b0;
    if (bus.mov_en) begin
      isr_d = bus.mov_in;
      cnt_d = 6'd0;
    end else if (bus.push_en) begin
      if (bus.push_iffull && (cnt_q < thresh)) begin
        isr_d = isr_q;
      end else if (!bus.fifo_full) begin
        fifo_data_d = isr_q;
        fifo_push_d = 1'b1;
        isr_d       = 32'd0;
        cnt_d       = 6'd0;
      end else if (bus.push_block) begin
        stall_d = 1'b1;
      end else begin
        // Non-blocking PUSH into a full FIFO drops the word but still clears the ISR.
        isr_d = 32'd0;
        cnt_d = 6'd0;
      end
    end else if (bus.shift_en) begin
      if (bus.autopush && (next_cnt >= thresh)) begin
        if (!bus.fifo_full) begin
          fifo_data_d = shifted;
          fifo_push_d = 1'b1;
          isr_d       = 32'd0;
          cnt_d       = 6'd0;
        end else begin
          stall_d = 1'b1;
        end
      end else begin
        isr_d = shifted;
        cnt_d = next_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr_q       <= 32'd0;
      cnt_q       <= 6'd0;
      fifo_data_q <= 32'd0;
      fifo_push_q <= 1'b0;
    end else begin
      isr_q       <= isr_d;
      cnt_q       <= cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_push_q <= fifo_push_d;
    end
  end

  assign bus.isr                 = isr_q;
  assign bus.input_shift_counter = cnt_q;
  assign bus.fifo_data           = fifo_data_q;
  assign bus.fifo_push           = fifo_push_q;
  // Held in reset the sequencer must never see a stall, even with a blocked PUSH pending.
  assign bus.stall               = stall_d & ~rst;

endmodule

// File: tb/tb_input_shift_register.sv
// Directed test of input_shift_register: IN left/right, saturation, autopush, PUSH variants,
// MOV and asynchronous reset, each against hand-computed values.
module tb_input_shift_register;

  logic clk;
  logic rst;
  input_shift_register_if bus ();

  input_shift_register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.mov_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.push_en  = 1'b0;
  endtask

  task automatic shift_in(input logic dir, input logic [4:0] cnt, input logic [31:0] data);
    idle();
    bus.shift_en    = 1'b1;
    bus.shiftdir    = dir;
    bus.shift_count = cnt;
    bus.in_data     = data;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_isr, input logic [5:0] e_cnt,
                             input logic e_push);
    check({tag, ".isr"}, bus.isr, e_isr);
    check({tag, ".cnt"}, {26'd0, bus.input_shift_counter}, {26'd0, e_cnt});
    check({tag, ".push"}, {31'd0, bus.fifo_push}, {31'd0, e_push});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.mov_in = '0; bus.mov_en = 1'b0; bus.in_data = '0; bus.shift_en = 1'b0;
    bus.shift_count = '0; bus.shiftdir = 1'b0; bus.autopush = 1'b0; bus.push_thresh = '0;
    bus.push_en = 1'b0; bus.push_iffull = 1'b0; bus.push_block = 1'b0; bus.fifo_full = 1'b0;
    tick(); tick();
    check_state("reset", 32'd0, 6'd0, 1'b0);
    check("reset.fdata", bus.fifo_data, 32'd0);
    rst = 1'b0;
    tick();

    // Four 8-bit left shifts fill the word and saturate the counter.
    shift_in(1'b0, 5'd8, 32'h11); tick();
    check_state("inL1", 32'h11, 6'd8, 1'b0);
    shift_in(1'b0, 5'd8, 32'hFF22); tick();
    check_state("inL2", 32'h1122, 6'd16, 1'b0);
    shift_in(1'b0, 5'd8, 32'h33); tick();
    shift_in(1'b0, 5'd8, 32'h44); tick();
    check_state("inL4", 32'h11223344, 6'd32, 1'b0);

    // Full-width right shift, then a 4-bit right shift with counter already saturated.
    shift_in(1'b1, 5'd0, 32'hDEADBEEF); tick();
    check_state("inR32", 32'hDEADBEEF, 6'd32, 1'b0);
    shift_in(1'b1, 5'd4, 32'hFFFF_FFFA); tick();
    check_state("inR4", 32'hADEADBEE, 6'd32, 1'b0);

    // Clear via MOV, then autopush at threshold 16.
    idle(); bus.mov_en = 1'b1; bus.mov_in = 32'd0; tick();
    check_state("mov0", 32'd0, 6'd0, 1'b0);
    bus.autopush = 1'b1; bus.push_thresh = 5'd16;
    shift_in(1'b0, 5'd8, 32'hAB); tick();
    check_state("ap1", 32'hAB, 6'd8, 1'b0);
    shift_in(1'b0, 5'd8, 32'hCD);
    check("ap2.stall", {31'd0, bus.stall}, 32'd0);
    tick();
    check_state("ap2", 32'd0, 6'd0, 1'b1);
    check("ap2.fdata", bus.fifo_data, 32'h0000ABCD);
    idle(); tick();
    check("ap.idle.push", {31'd0, bus.fifo_push}, 32'd0);
    check("ap.idle.fdata", bus.fifo_data, 32'h0000ABCD);

    // Autopush into a full FIFO stalls until space appears.
    shift_in(1'b0, 5'd8, 32'hAB); tick();
    bus.fifo_full = 1'b1;
    shift_in(1'b0, 5'd8, 32'hCD); #1;
    check("apf.stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check_state("apf.hold", 32'hAB, 6'd8, 1'b0);
    bus.fifo_full = 1'b0; #1;
    check("apf.release.stall", {31'd0, bus.stall}, 32'd0);
    tick();
    check_state("apf.push", 32'd0, 6'd0, 1'b1);
    check("apf.fdata", bus.fifo_data, 32'h0000ABCD);

    // PUSH variants with autopush off.
    bus.autopush = 1'b0; bus.push_thresh = 5'd0;
    shift_in(1'b0, 5'd8, 32'hAB); tick();
    idle(); bus.push_en = 1'b1; bus.push_iffull = 1'b1; #1;
    check("iffull.stall", {31'd0, bus.stall}, 32'd0);
    tick();
    check_state("iffull", 32'hAB, 6'd8, 1'b0);
    bus.push_iffull = 1'b0; bus.push_block = 1'b0; bus.fifo_full = 1'b1; tick();
    check_state("noblk", 32'd0, 6'd0, 1'b0);
    check("noblk.fdata", bus.fifo_data, 32'h0000ABCD);
    bus.fifo_full = 1'b0;
    shift_in(1'b0, 5'd8, 32'h5A); tick();
    idle(); bus.push_en = 1'b1; bus.push_block = 1'b1; bus.fifo_full = 1'b1; #1;
    check("blk.stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check_state("blk", 32'h5A, 6'd8, 1'b0);
    bus.fifo_full = 1'b0; tick();
    check_state("push", 32'd0, 6'd0, 1'b1);
    check("push.fdata", bus.fifo_data, 32'h5A);

    // MOV after 20 bits shifted in.
    shift_in(1'b0, 5'd20, 32'hFFF12345); tick();
    check_state("in20", 32'h12345, 6'd20, 1'b0);
    idle(); bus.mov_en = 1'b1; bus.mov_in = 32'h12345678; tick();
    check_state("mov", 32'h12345678, 6'd0, 1'b0);

    // Asynchronous reset in the middle of a blocked PUSH.
    idle(); bus.push_en = 1'b1; bus.push_block = 1'b1; bus.fifo_full = 1'b1; #1;
    check("pre_rst.stall", {31'd0, bus.stall}, 32'd1);
    #1 rst = 1'b1; #1;
    check_state("rst", 32'd0, 6'd0, 1'b0);
    check("rst.fdata", bus.fifo_data, 32'd0);
    check("rst.stall", {31'd0, bus.stall}, 32'd0);
    idle(); tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
